// File: rtl/mips_cpu_muldiv_pkg.sv
// mips_cpu_muldiv_pkg: op codes, FSM states and constants for the HI/LO multiply/divide unit
package mips_cpu_muldiv_pkg;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_LO    = 3'd6;
  localparam logic [2:0] OP_HI    = 3'd7;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// mips_cpu_muldiv_if: request/result bus between the pipeline (master) and the mul/div unit (slave)
interface mips_cpu_muldiv_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a, b, hi, lo;
  logic [2:0] op;
  logic write, busy, done;
  modport master(output a, b, op, write, input busy, done, hi, lo);
  modport slave(input a, b, op, write, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_signfix.sv
// mips_cpu_muldiv_signfix: operand magnitudes and sign correction of mul/div results
module mips_cpu_muldiv_signfix #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic [WIDTH-1:0]   abs_a,
  output logic [WIDTH-1:0]   abs_b,
  input  logic [2*WIDTH-1:0] acc,
  input  logic               mul,
  input  logic               neg_q,
  input  logic               neg_r,
  output logic [2*WIDTH-1:0] res
);
  always_comb begin
    abs_a = sgn && a[WIDTH-1] ? -a : a;
    abs_b = sgn && b[WIDTH-1] ? -b : b;
    res = mul ? (neg_q ? -acc : acc)
              : {neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                 neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]};
  end
endmodule

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative HI/LO multiply/divide unit with busy/done handshake.
// Define MIPS_MULDIV_FAST_MULT_EN for a single-cycle multiply; division stays iterative.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input logic clk,
  input logic reset,
  mips_cpu_muldiv_if.slave bus
);
  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
`ifdef MIPS_MULDIV_FAST_MULT_EN
  localparam state_t MUL_GO = FIX;
`else
  localparam state_t MUL_GO = MUL;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, res;
  logic [WIDTH-1:0] m, hi, lo, abs_a, abs_b;
  logic [WIDTH:0] mul_sum, div_t;
  logic is_mul, neg_q, neg_r, div0, done, mul_op, div_op, sgn;
  assign mul_op = bus.op == OP_MULT || bus.op == OP_MULTU;
  assign div_op = bus.op == OP_DIV || bus.op == OP_DIVU;
  assign sgn = bus.op == OP_MULT || bus.op == OP_DIV;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
  assign div_t = acc[2*WIDTH-1:WIDTH-1];
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.hi = hi;
  assign bus.lo = lo;
  mips_cpu_muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .a(bus.a), .b(bus.b), .sgn(sgn), .abs_a(abs_a), .abs_b(abs_b),
    .acc(acc), .mul(is_mul), .neg_q(neg_q), .neg_r(neg_r), .res(res)
  );
  always_comb begin
    state_n = state == IDLE ? (!bus.write ? IDLE : mul_op ? MUL_GO : div_op ? DIV : IDLE)
            : state == FIX ? IDLE
            : cnt == LAST ? FIX : state;
  end
  // acc holds {partial high, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      m <= '0;
      hi <= '0;
      lo <= '0;
      is_mul <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= state == FIX;
      case (state)
        IDLE: begin
          cnt <= '0;
          m <= mul_op ? abs_a : abs_b;
          is_mul <= mul_op;
          neg_q <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          neg_r <= sgn && bus.a[WIDTH-1];
          div0 <= bus.b == '0;
`ifdef MIPS_MULDIV_FAST_MULT_EN
          acc <= mul_op ? {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
`else
          acc <= {{WIDTH{1'b0}}, mul_op ? abs_b : abs_a};
`endif
          if (bus.write && bus.op == OP_LO) lo <= bus.a;
          if (bus.write && bus.op == OP_HI) hi <= bus.a;
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          acc <= div_t >= {1'b0, m} ? {div_t[WIDTH-1:0] - m, acc[WIDTH-2:0], 1'b1}
                                    : {div_t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          hi <= res[2*WIDTH-1:WIDTH];
          lo <= !is_mul && div0 ? DIV0_QUOTIENT : res[WIDTH-1:0];
        end
      endcase
    end
  end
endmodule
